// File: rtl/dsc_mul_param.sv
// ============================================================================
// Module   : dsc_mul_param
// Brief    : Unary stochastic-style multiplier. An odometer of N counters
//            sweeps the operand space and z counts the cycles where every
//            operand exceeds its counter, giving the exact N-way product.
//            Optional macro DSC_EARLY_STOP_EN ends the sweep as soon as no
//            further product bit can be set.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dsc_mul_param #(
    parameter int SNG_WIDTH  = 4,
    parameter int NUM_INPUTS = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  operands,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z,
    output logic                             busy,
    output logic                             done,
    output logic                             ov
);

    localparam int W  = SNG_WIDTH;
    localparam int N  = NUM_INPUTS;
    localparam int ZW = N * W;
    localparam logic [W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [W-1:0]  r_op  [N];
    logic [W-1:0]  r_cnt [N];
    logic [ZW-1:0] r_z;

    logic [W-1:0]  w_op_in  [N];
    logic [W-1:0]  w_op_sel [N];
    logic [N-1:0]  w_inc;
    logic [N-1:0]  w_s;
    logic          w_p;
    logic          w_last;

    generate
        for (genvar g = 0; g < N; g++) begin : g_unpack
            assign w_op_in[g] = operands[g*W +: W];
        end
    endgenerate

`ifdef DSC_EARLY_STOP_EN
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    logic [IW-1:0] w_min_idx;
    logic [W-1:0]  w_min_val;

    // Smallest operand drives the outermost counter so the sweep can stop
    // once that counter passes it.
    always_comb begin
        w_min_idx = IW'(N - 1);
        w_min_val = w_op_in[N-1];
        for (int k = 0; k < N - 1; k++) begin
            if (w_op_in[k] < w_min_val) begin
                w_min_idx = IW'(k);
                w_min_val = w_op_in[k];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (k == N - 1)
                w_op_sel[k] = w_min_val;
            else if (IW'(k) == w_min_idx)
                w_op_sel[k] = w_op_in[N-1];
            else
                w_op_sel[k] = w_op_in[k];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_op_sel[k] = w_op_in[k];
        end
    end
`endif

    // Odometer carry chain and unary stream bits.
    always_comb begin
        w_inc[0] = 1'b1;
        for (int k = 1; k < N; k++) begin
            w_inc[k] = w_inc[k-1] & (r_cnt[k-1] == c_CNT_MAX);
        end
        for (int k = 0; k < N; k++) begin
            w_s[k] = (r_op[k] > r_cnt[k]);
        end
        w_p = &w_s;
    end

`ifdef DSC_EARLY_STOP_EN
    assign w_last = (r_op[N-1] == '0) ||
                    (w_inc[N-1] && (r_cnt[N-1] == (r_op[N-1] - W'(1))));
`else
    assign w_last = w_inc[N-1] && (r_cnt[N-1] == c_CNT_MAX);
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        ov     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    ov     = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_z <= '0;
            for (int k = 0; k < N; k++) begin
                r_op[k]  <= '0;
                r_cnt[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_z <= '0;
                        for (int k = 0; k < N; k++) begin
                            r_op[k]  <= w_op_sel[k];
                            r_cnt[k] <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_p)
                        r_z <= r_z + ZW'(1);
                    for (int k = 0; k < N; k++) begin
                        if (w_inc[k])
                            r_cnt[k] <= r_cnt[k] + W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign z = r_z;

endmodule

`default_nettype wire
